// File: rtl/ddram_responder.sv
// rtl/ddram_responder.sv - block-RAM backed responder for the 64-bit DDRAM_* burst port
//
// Purpose: memory side of the DDRAM_* burst port. Stores 2**ADDR_W 64-bit words in on-chip RAM
//   and serves byte-enabled write bursts and fixed-latency read bursts, so DDR clients can be
//   connected unchanged when no HPS DDR bridge is present.
// Parameters:
//   ADDR_W     word-index width (RAM depth 2**ADDR_W words)
//   RD_LATENCY cycles from read accept edge to first DDRAM_DOUT_READY (2..15)
// Ports:
//   DDRAM_CLK        clock, all logic on rising edge
//   reset            asynchronous active-high reset (RAM contents are kept)
//   DDRAM_BUSY       waitrequest: command not accepted this cycle
//   DDRAM_BURSTCNT   burst length in words, 0 treated as 1
//   DDRAM_ADDR       word address, only the low ADDR_W bits are used
//   DDRAM_RD         read request
//   DDRAM_WE         write request / write beat
//   DDRAM_DIN        write data
//   DDRAM_BE         byte enables, bit n covers DIN[8n+7:8n]
//   DDRAM_DOUT       read data, holds the last word between strobes
//   DDRAM_DOUT_READY one-cycle strobe per read word
// Build option: DDRAM_RESP_STALL_EN adds LFSR-driven random BUSY in IDLE/WBURST.
module ddram_responder #(
  parameter int ADDR_W     = 12,
  parameter int RD_LATENCY = 4
) (
  input  logic        DDRAM_CLK,
  input  logic        reset,
  output logic        DDRAM_BUSY,
  input  logic [7:0]  DDRAM_BURSTCNT,
  input  logic [28:0] DDRAM_ADDR,
  input  logic        DDRAM_RD,
  input  logic        DDRAM_WE,
  input  logic [63:0] DDRAM_DIN,
  input  logic [7:0]  DDRAM_BE,
  output logic [63:0] DDRAM_DOUT,
  output logic        DDRAM_DOUT_READY
);

  localparam int DEPTH = 1 << ADDR_W;
  // The RAM read register and DOUT register form two pipeline stages, so the
  // first RAM read is issued RD_LATENCY-1 edges after the accept edge.
  localparam logic [3:0] WAIT_LAST = 4'(RD_LATENCY - 2);

  typedef enum logic [1:0] {IDLE, WBURST, RWAIT, RBURST} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        wr_rem;
  logic [7:0]        iss_rem;
  logic [7:0]        out_rem;
  logic [3:0]        wcnt;
  logic              q_valid;
  logic              busy_r;
  logic [63:0]       mem [DEPTH];
  logic [63:0]       ram_q;
  logic              stall;

  logic [7:0]        cnt_eff;
  logic [ADDR_W-1:0] cmd_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic              idle_we;
  logic              idle_rd;
  logic              beat_we;
  logic              wr_en;
  logic              issue;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^DDRAM_ADDR[28:ADDR_W];

`ifdef DDRAM_RESP_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // busy_r is only set in the read states, whose timing must not be disturbed
  assign stall = (lfsr[1:0] == 2'b11) && !busy_r;
`else
  assign stall = 1'b0;
`endif

  assign DDRAM_BUSY = busy_r | stall;

  assign cnt_eff = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;
  assign cmd_idx = DDRAM_ADDR[ADDR_W-1:0];
  // A simultaneous RD and WE in IDLE is taken as a write; the read is dropped.
  assign idle_we = (state == IDLE) && DDRAM_WE && !DDRAM_BUSY;
  assign idle_rd = (state == IDLE) && DDRAM_RD && !DDRAM_WE && !DDRAM_BUSY;
  assign beat_we = (state == WBURST) && DDRAM_WE && !DDRAM_BUSY;
  assign wr_en   = (idle_we || beat_we) && !reset;
  assign wr_idx  = (state == IDLE) ? cmd_idx : ptr;
  assign issue   = ((state == RWAIT) || (state == RBURST)) &&
                   (wcnt == WAIT_LAST) && (iss_rem != 8'd0);

  // Byte-enable RAM with a registered read port. Reads only start after the
  // read command is accepted, so every earlier write is already in the array.
  always_ff @(posedge DDRAM_CLK) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (DDRAM_BE[b]) mem[wr_idx][8*b +: 8] <= DDRAM_DIN[8*b +: 8];
      end
    end
    ram_q <= mem[ptr];
  end

  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      ptr              <= '0;
      wr_rem           <= '0;
      iss_rem          <= '0;
      out_rem          <= '0;
      wcnt             <= '0;
      q_valid          <= 1'b0;
      busy_r           <= 1'b0;
      DDRAM_DOUT       <= '0;
      DDRAM_DOUT_READY <= 1'b0;
    end else begin
      q_valid          <= 1'b0;
      DDRAM_DOUT_READY <= 1'b0;
      case (state)
        IDLE: begin
          if (idle_we) begin
            if (cnt_eff > 8'd1) begin
              state  <= WBURST;
              wr_rem <= cnt_eff - 8'd1;
              ptr    <= cmd_idx + 1'b1;
            end
          end else if (idle_rd) begin
            state   <= RWAIT;
            busy_r  <= 1'b1;
            ptr     <= cmd_idx;
            iss_rem <= cnt_eff;
            out_rem <= cnt_eff;
            wcnt    <= '0;
          end
        end
        WBURST: begin
          if (beat_we) begin
            ptr    <= ptr + 1'b1;
            wr_rem <= wr_rem - 8'd1;
            if (wr_rem == 8'd1) state <= IDLE;
          end
        end
        RWAIT, RBURST: begin
          if (wcnt != WAIT_LAST) wcnt <= wcnt + 4'd1;
          if (issue) begin
            ptr     <= ptr + 1'b1;
            iss_rem <= iss_rem - 8'd1;
            q_valid <= 1'b1;
          end
          if (q_valid) begin
            DDRAM_DOUT       <= ram_q;
            DDRAM_DOUT_READY <= 1'b1;
            out_rem          <= out_rem - 8'd1;
            state            <= RBURST;
          end else if ((state == RBURST) && (out_rem == 8'd0)) begin
            // BUSY covered the last-word cycle; release it one cycle later
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddram_responder.sv
// tb/tb_ddram_responder.sv - randomized self-checking bench for ddram_responder
module tb_ddram_responder;

  localparam int ADDR_W = 12;
  localparam int RD_LAT = 4;
  localparam int MASK   = (1 << ADDR_W) - 1;
`ifdef DDRAM_RESP_STALL_EN
  localparam int N_RAND = 1000;
`else
  localparam int N_RAND = 300;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ddram_busy;
  logic [7:0]  ddram_burstcnt = '0;
  logic [28:0] ddram_addr = '0;
  logic        ddram_rd = 1'b0;
  logic        ddram_we = 1'b0;
  logic [63:0] ddram_din = '0;
  logic [7:0]  ddram_be = '0;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          mptr = 0;
  logic [63:0] model [4096];

  ddram_responder #(.ADDR_W(ADDR_W), .RD_LATENCY(RD_LAT)) dut (
    .DDRAM_CLK       (clk),
    .reset           (reset),
    .DDRAM_BUSY      (ddram_busy),
    .DDRAM_BURSTCNT  (ddram_burstcnt),
    .DDRAM_ADDR      (ddram_addr),
    .DDRAM_RD        (ddram_rd),
    .DDRAM_WE        (ddram_we),
    .DDRAM_DIN       (ddram_din),
    .DDRAM_BE        (ddram_be),
    .DDRAM_DOUT      (ddram_dout),
    .DDRAM_DOUT_READY(ddram_dout_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] din,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  // Present a command from a falling edge and hold it until a rising edge sees BUSY low.
  // acc is the cycle count just after the accepting edge.
  task automatic drive_cmd(input logic rd, input logic we, input logic [28:0] addr,
                           input logic [7:0] cnt, input logic [63:0] din,
                           input logic [7:0] be, output int acc);
    int tries;
    @(negedge clk);
    ddram_rd = rd;
    ddram_we = we;
    ddram_addr = addr;
    ddram_burstcnt = cnt;
    ddram_din = din;
    ddram_be = be;
    tries = 0;
    while (ddram_busy && tries < 64) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 64) check_eq("accept_timeout", 64'(tries), 64'd0);
    @(posedge clk);
    #1;
    acc = cyc;
    ddram_rd = 1'b0;
    ddram_we = 1'b0;
  endtask

  task automatic do_write(input logic [28:0] addr, input logic [7:0] cnt,
                          input logic [63:0] din, input logic [7:0] be);
    int acc;
    drive_cmd(1'b0, 1'b1, addr, cnt, din, be, acc);
    model[addr[11:0]] = merge(model[addr[11:0]], din, be);
    mptr = (int'(addr[11:0]) + 1) & MASK;
  endtask

  // Follow-on beat: RD high and a random ADDR/BURSTCNT must be ignored mid-burst.
  task automatic wr_beat(input logic [63:0] din, input logic [7:0] be, input int gap);
    int acc;
    repeat (gap) @(negedge clk);
    drive_cmd(1'b1, 1'b1, 29'($urandom), 8'($urandom), din, be, acc);
    model[mptr] = merge(model[mptr], din, be);
    mptr = (mptr + 1) & MASK;
  endtask

  task automatic do_read(input logic [28:0] addr, input logic [7:0] cnt, input string tag);
    int          acc;
    int          n;
    int          off;
    logic [63:0] exp_q [$];
    n = (cnt == 8'd0) ? 1 : int'(cnt);
    for (int i = 0; i < n; i++) exp_q.push_back(model[(int'(addr[11:0]) + i) & MASK]);
    drive_cmd(1'b1, 1'b0, addr, cnt, {$urandom, $urandom}, 8'($urandom), acc);
    off = 0;
    while (off < RD_LAT + n) begin
      @(negedge clk);
      off = cyc - acc;
      if (off < RD_LAT + n) check_eq({tag, "_busy"}, ddram_busy, 1'b1);
`ifndef DDRAM_RESP_STALL_EN
      else check_eq({tag, "_busy_end"}, ddram_busy, 1'b0);
`endif
      check_eq({tag, "_ready"}, ddram_dout_ready, (off >= RD_LAT) && (off < RD_LAT + n));
      if (off >= RD_LAT && off < RD_LAT + n) check_eq({tag, "_data"}, ddram_dout, exp_q[off - RD_LAT]);
      if (off == RD_LAT + n) check_eq({tag, "_hold"}, ddram_dout, exp_q[n - 1]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    int          pulses;
    logic [28:0] a;
    logic [7:0]  c;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", ddram_busy, 1'b0);
    check_eq("rst_ready", ddram_dout_ready, 1'b0);
    check_eq("rst_dout", ddram_dout, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_write(29'h10, 8'd1, 64'h1122334455667788, 8'hFF);
    do_read(29'h10, 8'd1, "single");

    do_write(29'h20, 8'd4, 64'd0, 8'hFF);
    wr_beat(64'd1, 8'hFF, 0);
    wr_beat(64'd2, 8'hFF, 2);
    wr_beat(64'd3, 8'hFF, 0);
    do_read(29'h20, 8'd4, "burst4");

    do_write(29'h30, 8'd1, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    do_write(29'h30, 8'd1, 64'd0, 8'h0F);
    do_read(29'h30, 8'd1, "be_partial");
    do_write(29'h30, 8'd1, {$urandom, $urandom}, 8'h00);
    do_read(29'h30, 8'd1, "be_zero");

    do_write(29'hFFF, 8'd1, 64'hA5A5_0000_0000_0FFF, 8'hFF);
    do_write(29'h000, 8'd1, 64'hB0B0_0000_0000_0000, 8'hFF);
    do_read(29'hFFF, 8'd2, "wrap");

    do_write(29'h40, 8'd0, 64'hC0C0_C0C0_0000_0040, 8'hFF);
    do_write(29'h41, 8'd0, 64'hD0D0_D0D0_0000_0041, 8'hFF);
    do_read(29'h40, 8'd0, "cnt0");
    do_read(29'h40, 8'd2, "cnt0_pair");

    drive_cmd(1'b1, 1'b1, 29'h50, 8'd1, 64'hE0E0_E0E0_E0E0_0050, 8'hFF, acc);
    model[12'h50] = 64'hE0E0_E0E0_E0E0_0050;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (ddram_dout_ready) pulses++;
    end
    check_eq("rdwe_no_read", 64'(pulses), 64'd0);
    do_read(29'h50, 8'd1, "rdwe_write");

    drive_cmd(1'b1, 1'b0, 29'h20, 8'd8, 64'd0, 8'h00, acc);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_eq("async_rst_busy", ddram_busy, 1'b0);
    check_eq("async_rst_ready", ddram_dout_ready, 1'b0);
    check_eq("async_rst_dout", ddram_dout, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (ddram_dout_ready) pulses++;
    end
    check_eq("abort_no_ready", 64'(pulses), 64'd0);
    do_read(29'h20, 8'd4, "post_rst");

    do_write(29'h100, 8'd72, {$urandom, $urandom}, 8'hFF);
    for (int i = 1; i < 72; i++) wr_beat({$urandom, $urandom}, 8'hFF, 0);

    for (int i = 0; i < N_RAND; i++) begin
      a = {17'($urandom), 12'(12'h100 + $urandom_range(0, 63))};
      c = 8'($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, c, {$urandom, $urandom}, 8'($urandom));
        for (int k = 1; k < int'(c); k++) wr_beat({$urandom, $urandom}, 8'($urandom), $urandom_range(0, 2));
      end else begin
        do_read(a, c, "rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
